// File: rtl/ansi_pkg.sv
// Shared types, byte constants and byte-class helpers for the ANSI CSI parser.
package ansi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ESC,
    ST_CSI,
    ST_CSI_DISCARD
  } state_t;

  localparam logic [7:0] ESC       = 8'h1B;
  localparam logic [7:0] CSI_INTRO = 8'h5B;
  localparam logic [7:0] CAN       = 8'h18;
  localparam logic [7:0] SUB       = 8'h1A;
  localparam logic [7:0] DEL       = 8'h7F;
  localparam logic [7:0] QMARK     = 8'h3F;
  localparam logic [7:0] SEMI      = 8'h3B;
  localparam logic [7:0] C0_HI     = 8'h1F;
  localparam logic [7:0] INTER_LO  = 8'h20;
  localparam logic [7:0] INTER_HI  = 8'h2F;
  localparam logic [7:0] DIGIT_LO  = 8'h30;
  localparam logic [7:0] DIGIT_HI  = 8'h39;
  localparam logic [7:0] FINAL_LO  = 8'h40;
  localparam logic [7:0] FINAL_HI  = 8'h7E;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= DIGIT_LO) && (b <= DIGIT_HI);
  endfunction

  function automatic logic is_inter(input logic [7:0] b);
    return (b >= INTER_LO) && (b <= INTER_HI);
  endfunction

  function automatic logic is_final(input logic [7:0] b);
    return (b >= FINAL_LO) && (b <= FINAL_HI);
  endfunction

  function automatic logic is_abort(input logic [7:0] b);
    return (b == CAN) || (b == SUB);
  endfunction

endpackage

// File: rtl/ansi_param_acc.sv
// One saturating decimal field accumulator: val <= val*10 + digit, clamped to all-ones.
module ansi_param_acc
#(
  parameter int PARAM_W = 8
)(
  input  logic               clk,
  input  logic               resetn,
  input  logic               clr,
  input  logic               en,
  input  logic [3:0]         digit,
  output logic [PARAM_W-1:0] val
);

  // 4 extra bits hold (2^W-1)*10+9 without wrap.
  localparam int XW = PARAM_W + 4;
  localparam logic [XW-1:0] SAT = {4'd0, {PARAM_W{1'b1}}};

  logic [XW-1:0] nxt;
  assign nxt = ({4'd0, val} * XW'(10)) + {{PARAM_W{1'b0}}, digit};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)  val <= '0;
    else if (clr) val <= '0;
    else if (en)  val <= (nxt > SAT) ? {PARAM_W{1'b1}} : nxt[PARAM_W-1:0];
  end

endmodule

// File: rtl/ansi_csi_parser.sv
// ANSI escape / CSI byte-stream parser with registered pass-through and command outputs.
// Optional '?' private-mode prefix is enabled with macro ANSI_PRIVATE_MODE_EN.
module ansi_csi_parser
  import ansi_pkg::*;
#(
  parameter int MAX_PARAMS = 4,
  parameter int PARAM_W    = 8
)(
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          rxDataInValid,
  input  logic [7:0]                    rxDataIn,
  output logic                          rxANSIDataOutValid,
  output logic [7:0]                    rxANSIDataOut,
  output logic                          cmdValid,
  output logic                          cmdCsi,
  output logic [7:0]                    cmdFinal,
  output logic [7:0]                    cmdInter,
  output logic                          cmdPrivate,
  output logic [4:0]                    cmdNumParams,
  output logic [MAX_PARAMS*PARAM_W-1:0] cmdParams
);

`ifdef ANSI_PRIVATE_MODE_EN
  localparam logic PRIV_EN = 1'b1;
`else
  localparam logic PRIV_EN = 1'b0;
`endif

  // idx must reach MAX_PARAMS itself to mark "all fields used".
  localparam int IW = $clog2(MAX_PARAMS + 1);

  state_t        state;
  logic [IW-1:0] idx;
  logic          seen;
  logic          inter_seen;
  logic          first;
  logic          priv;
  logic          cmd_priv;
  logic [7:0]    inter;
  logic [4:0]    num_params;
  logic          acc_clr;
  logic [MAX_PARAMS-1:0]              acc_en;
  logic [MAX_PARAMS-1:0][PARAM_W-1:0] acc_val;

  wire [7:0] b  = rxDataIn;
  wire       go = rxDataInValid && (rxDataIn != DEL);

  always_comb begin
    acc_clr = go && (state == ST_ESC) && (b == CSI_INTRO);
    acc_en  = '0;
    if (go && (state == ST_CSI) && is_digit(b) && !inter_seen)
      for (int i = 0; i < MAX_PARAMS; i++) acc_en[i] = (idx == IW'(i));
  end

  always_comb begin
    num_params = 5'd0;
    if (seen)
      num_params = (32'(idx) >= MAX_PARAMS) ? 5'(MAX_PARAMS) : 5'(32'(idx) + 1);
  end

  for (genvar g = 0; g < MAX_PARAMS; g++) begin : g_acc
    ansi_param_acc #(.PARAM_W(PARAM_W)) u_acc (
      .clk    (clk),
      .resetn (resetn),
      .clr    (acc_clr),
      .en     (acc_en[g]),
      .digit  (b[3:0]),
      .val    (acc_val[g])
    );
  end

  assign cmdPrivate = PRIV_EN & cmd_priv;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state              <= ST_IDLE;
      idx                <= '0;
      seen               <= 1'b0;
      inter_seen         <= 1'b0;
      first              <= 1'b0;
      priv               <= 1'b0;
      inter              <= 8'h00;
      rxANSIDataOutValid <= 1'b0;
      rxANSIDataOut      <= 8'h00;
      cmdValid           <= 1'b0;
      cmdCsi             <= 1'b0;
      cmdFinal           <= 8'h00;
      cmdInter           <= 8'h00;
      cmd_priv           <= 1'b0;
      cmdNumParams       <= 5'd0;
      cmdParams          <= '0;
    end else begin
      rxANSIDataOutValid <= 1'b0;
      cmdValid           <= 1'b0;
      if (go) begin
        unique case (state)
          ST_IDLE: begin
            if (b == ESC) state <= ST_ESC;
            else begin
              rxANSIDataOutValid <= 1'b1;
              rxANSIDataOut      <= b;
            end
          end
          ST_ESC: begin
            if (b == CSI_INTRO) begin
              state      <= ST_CSI;
              idx        <= '0;
              seen       <= 1'b0;
              inter      <= 8'h00;
              inter_seen <= 1'b0;
              priv       <= 1'b0;
              first      <= 1'b1;
            end else if (b != ESC) begin
              state        <= ST_IDLE;
              cmdValid     <= 1'b1;
              cmdCsi       <= 1'b0;
              cmdFinal     <= b;
              cmdInter     <= 8'h00;
              cmd_priv     <= 1'b0;
              cmdNumParams <= 5'd0;
              cmdParams    <= '0;
            end
          end
          ST_CSI: begin
            first <= 1'b0;
            if (is_abort(b)) state <= ST_IDLE;
            else if (b == ESC) state <= ST_ESC;
            else if (b <= C0_HI) begin
              rxANSIDataOutValid <= 1'b1;
              rxANSIDataOut      <= b;
            end else if (is_digit(b) || (b == SEMI)) begin
              // Parameters after an intermediate are malformed; drop the sequence.
              if (inter_seen) state <= ST_CSI_DISCARD;
              else begin
                seen <= 1'b1;
                if ((b == SEMI) && (32'(idx) < MAX_PARAMS)) idx <= idx + IW'(1);
              end
            end else if (is_inter(b)) begin
              inter      <= b;
              inter_seen <= 1'b1;
            end else if (is_final(b)) begin
              state        <= ST_IDLE;
              cmdValid     <= 1'b1;
              cmdCsi       <= 1'b1;
              cmdFinal     <= b;
              cmdInter     <= inter;
              cmd_priv     <= priv;
              cmdNumParams <= num_params;
              cmdParams    <= acc_val;
            end else if (PRIV_EN && first && (b == QMARK)) priv <= 1'b1;
            // ':', '<'..'?' and bytes >= 0x80 are not supported parameter syntax.
            else state <= ST_CSI_DISCARD;
          end
          ST_CSI_DISCARD: begin
            if (is_abort(b)) state <= ST_IDLE;
            else if (b == ESC) state <= ST_ESC;
            else if (b <= C0_HI) begin
              rxANSIDataOutValid <= 1'b1;
              rxANSIDataOut      <= b;
            end else if (is_final(b)) state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/ansi_csi_parser.md
ANSI_CSI_PARSER -- requirements
Module: ansi_csi_parser

Interface
REQ-001 SHALL have parameter MAX_PARAMS, default 4, number of numeric CSI parameters captured (legal range 1..16).
REQ-002 SHALL have parameter PARAM_W, default 8, bit width of each captured parameter (legal range 4..16).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rxDataInValid  input  1  one-cycle strobe qualifying rxDataIn; may be high every cycle.
REQ-006 SHALL have port rxDataIn  input  8  received UART byte.
REQ-007 SHALL have port rxANSIDataOutValid  output  1  one-cycle strobe, printable or control byte for the display.
REQ-008 SHALL have port rxANSIDataOut  output  8  pass-through byte.
REQ-009 SHALL have port cmdValid  output  1  one-cycle strobe, decoded escape or CSI command.
REQ-010 SHALL have port cmdCsi  output  1  1 for a CSI command (ESC [ ... final), 0 for a two-byte ESC command.
REQ-011 SHALL have port cmdFinal  output  8  final byte of the command.
REQ-012 SHALL have port cmdInter  output  8  last intermediate byte (0x20-0x2F), 0x00 if none.
REQ-013 SHALL have port cmdPrivate  output  1  '?' prefix present (forced to 0 when the private-mode feature is compiled out).
REQ-014 SHALL have port cmdNumParams  output  5  count of parameter fields, 0..MAX_PARAMS.
REQ-015 SHALL have port cmdParams  output  MAX_PARAMS*PARAM_W  parameters; field i occupies bits [i*PARAM_W +: PARAM_W].

Function
REQ-016 SHALL implement FSM states IDLE, ESC, CSI, CSI_DISCARD.
REQ-017 SHALL register all outputs; latency from the accepted byte to the output strobe SHALL be exactly 1 cycle.
REQ-018 SHALL never assert rxANSIDataOutValid and cmdValid in the same cycle; both are low when rxDataInValid was low.
REQ-019 IDLE: a byte other than 0x1B SHALL be passed through; 0x1B SHALL move to ESC with no output.
REQ-020 ESC: '[' (0x5B) SHALL move to CSI and clear all parameters, counts, inter and private; 0x1B SHALL stay in ESC; any other byte SHALL emit cmdValid with cmdCsi=0, cmdFinal=byte, cmdNumParams=0, and return to IDLE.
REQ-021 CSI digit '0'-'9': current field SHALL become field*10+digit, saturating at 2^PARAM_W-1; field marked present.
REQ-022 CSI ';': the field index SHALL advance; once the index reaches MAX_PARAMS, further digits and ';' SHALL be discarded without error.
REQ-023 cmdNumParams SHALL equal (semicolons+1) capped at MAX_PARAMS if any digit or ';' was seen, else 0; empty fields SHALL read 0.
REQ-024 CSI intermediate 0x20-0x2F SHALL be latched into cmdInter; a later digit or ';' SHALL move to CSI_DISCARD.
REQ-025 CSI final byte 0x40-0x7E SHALL emit cmdValid with cmdCsi=1 and return to IDLE; unused parameter fields SHALL read 0.
REQ-026 CSI or CSI_DISCARD C0 byte (0x00-0x1F, except 0x18, 0x1A, 0x1B) SHALL be passed through with the state held.
REQ-027 CSI or CSI_DISCARD 0x18 or 0x1A SHALL abort to IDLE with no output; 0x1B SHALL abort to ESC with no output.
REQ-028 CSI_DISCARD SHALL consume bytes through the final byte, then return to IDLE with no cmdValid.
REQ-029 A byte 0x3C-0x3F SHALL move to CSI_DISCARD unless REQ-034 applies; 0x7F SHALL be ignored in every state.

Reset
REQ-030 resetn low SHALL force IDLE and set every output and internal accumulator to 0, asynchronously, including mid-sequence.
REQ-031 After resetn deassertion the first accepted byte SHALL be treated as an IDLE byte.

Configuration
REQ-032 SHALL use macro ANSI_PRIVATE_MODE_EN.
REQ-033 Without ANSI_PRIVATE_MODE_EN: '?' SHALL be treated under REQ-029, and cmdPrivate SHALL be a constant 0.
REQ-034 With ANSI_PRIVATE_MODE_EN: '?' as the first byte after '[' SHALL set cmdPrivate=1 and stay in CSI; '?' anywhere else SHALL follow REQ-029.

Structure
REQ-035 Shared package ansi_pkg SHALL hold the FSM state typedef and the byte constants ESC, CSI_INTRO, CAN, SUB, DEL, QMARK, SEMI, and the final/intermediate range bounds.
REQ-036 Sub-module ansi_param_acc SHALL be the one saturating decimal accumulator (PARAM_W-parameterised, with clear/digit/enable inputs).

Verification
REQ-037 "AB" -> two pass-through strobes 0x41, 0x42, each 1 cycle after input.
REQ-038 ESC [ 1 2 ; 3 4 H -> cmdValid, cmdCsi=1, cmdFinal=0x48, cmdNumParams=2, params 12, 34; no pass-through.
REQ-039 PARAM_W=8: ESC [ 9 9 9 m -> param0=255, cmdNumParams=1; ESC [ m -> cmdNumParams=0.
REQ-040 MAX_PARAMS=4: ESC [ 1;2;3;4;5;6 m -> cmdNumParams=4, params 1,2,3,4.
REQ-041 ESC [ 3 0x0D 1 J -> pass-through 0x0D mid-sequence, then cmd 0x4A with param 31; ESC [ 5 0x18 -> nothing; ESC [ 5 ESC 7 -> cmdCsi=0, cmdFinal=0x37.
REQ-042 ESC [ ? 2 5 l -> with macro: cmdPrivate=1, param 25; without macro: no cmdValid; resetn pulsed after ESC [ 1 -> next byte 'x' passes through.
